// File: rtl/reg_demux.sv
// reg_demux: routes each upstream word into one of NUM_OUTPUTS single-word
// holding registers with per-channel ack, flush and an out-of-range drop counter.
module reg_demux #(
   parameter  int NUM_OUTPUTS = 4,
   parameter  int DATA_WIDTH  = 8,
   localparam int SEL_W       = $clog2(NUM_OUTPUTS)
) (
   input  logic                              clk_in,
   input  logic                              rst_n_in,
   input  logic [DATA_WIDTH-1:0]             data_in,
   input  logic [SEL_W-1:0]                  select_in,
   input  logic                              valid_in,
   output logic                              ready_out,
   input  logic                              flush_in,
   output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] data_out,
   output logic [NUM_OUTPUTS-1:0]            valid_out,
   input  logic [NUM_OUTPUTS-1:0]            ack_in,
   output logic [7:0]                        drop_count_out,
   output logic                              error_out
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_st_e;

   chan_st_e                          state_q [NUM_OUTPUTS];
   chan_st_e                          state_d [NUM_OUTPUTS];
   logic [NUM_OUTPUTS*DATA_WIDTH-1:0] data_q, data_d;
   logic [7:0]                        drop_q, drop_d;
   logic                              error_q, error_d;
   logic                              oor, sel_full, sel_ack, xfer;
   logic [NUM_OUTPUTS-1:0]            wr;

   // Constant-false when NUM_OUTPUTS is a power of two.
   assign oor = {1'b0, select_in} >= (SEL_W+1)'(NUM_OUTPUTS);

   always_comb begin
      sel_full = 1'b0;
      sel_ack  = 1'b0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
         if (select_in == SEL_W'(i)) begin
            sel_full = (state_q[i] == FULL);
            sel_ack  = ack_in[i];
         end
      end
   end

   assign ready_out = !flush_in && (oor || !sel_full || sel_ack);
   assign xfer      = valid_in && ready_out;

   always_comb begin
      data_d = data_q;
      wr     = '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
         state_d[i] = state_q[i];
         wr[i]      = xfer && (select_in == SEL_W'(i));
         if (flush_in) begin
            state_d[i] = EMPTY;
         end else if (wr[i]) begin
            state_d[i] = FULL;
            data_d[i*DATA_WIDTH +: DATA_WIDTH] = data_in;
         end else if (ack_in[i]) begin
            state_d[i] = EMPTY;
         end
      end
   end

   always_comb begin
      error_d = xfer && oor;
      drop_d  = drop_q;
      if (error_d && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < NUM_OUTPUTS; i++) begin
            state_q[i] <= EMPTY;
         end
         data_q  <= '0;
         drop_q  <= '0;
         error_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_OUTPUTS; i++) begin
            state_q[i] <= state_d[i];
         end
         data_q  <= data_d;
         drop_q  <= drop_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      valid_out = '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
         valid_out[i] = (state_q[i] == FULL);
      end
   end

   assign data_out       = data_q;
   assign drop_count_out = drop_q;
   assign error_out      = error_q;

endmodule

// File: tb/tb_reg_demux.sv
// tb_reg_demux: directed and random checks of reg_demux (4-channel and
// 3-channel instances) with a per-channel scoreboard.
module tb_reg_demux;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [7:0]  d_data;
   logic [1:0]  d_sel;
   logic        d_valid, d_flush, d_ready, d_err;
   logic [3:0]  d_ack, d_vout;
   logic [31:0] d_dout;
   logic [7:0]  d_drop;

   logic [7:0]  t_data;
   logic [1:0]  t_sel;
   logic        t_valid, t_flush, t_ready, t_err;
   logic [2:0]  t_ack, t_vout;
   logic [23:0] t_dout;
   logic [7:0]  t_drop;

   reg_demux #(.NUM_OUTPUTS(4), .DATA_WIDTH(8)) dut4 (
      .clk_in(clk), .rst_n_in(rst_n), .data_in(d_data),
      .select_in(d_sel), .valid_in(d_valid), .ready_out(d_ready),
      .flush_in(d_flush), .data_out(d_dout), .valid_out(d_vout),
      .ack_in(d_ack), .drop_count_out(d_drop), .error_out(d_err)
   );

   reg_demux #(.NUM_OUTPUTS(3), .DATA_WIDTH(8)) dut3 (
      .clk_in(clk), .rst_n_in(rst_n), .data_in(t_data),
      .select_in(t_sel), .valid_in(t_valid), .ready_out(t_ready),
      .flush_in(t_flush), .data_out(t_dout), .valid_out(t_vout),
      .ack_in(t_ack), .drop_count_out(t_drop), .error_out(t_err)
   );

   int n_vec = 0;
   int n_err = 0;
   int npulse;
   int left;
   logic [7:0] sb [4][$];
   logic [3:0] mfull;
   logic [7:0] expw;
   logic       exp_rdy;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [1:0] s,
                      input logic [7:0] d, input logic [3:0] a,
                      input logic f);
      @(negedge clk);
      d_valid = v;
      d_sel   = s;
      d_data  = d;
      d_ack   = a;
      d_flush = f;
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      d_valid = 0; d_sel = 0; d_data = 0; d_ack = 0; d_flush = 0;
      t_valid = 0; t_sel = 0; t_data = 0; t_ack = 0; t_flush = 0;
      #1;
      chk("rst_vout", d_vout, 4'b0000);
      chk("rst_dout", d_dout, 32'h0);
      chk("rst_drop", d_drop, 8'h0);
      chk("rst_err", d_err, 1'b0);
      chk("rst_ready", d_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // single write to channel 2
      cyc(1, 2'd2, 8'hA5, 4'b0000, 0);
      chk("w2_ready", d_ready, 1'b1);
      cyc(0, 0, 0, 0, 0);
      chk("w2_vout", d_vout, 4'b0100);
      chk("w2_dout", d_dout, 32'h00A5_0000);

      // backpressure on full channel 1, then write with ack
      cyc(1, 2'd1, 8'h11, 4'b0000, 0);
      cyc(1, 2'd1, 8'h22, 4'b0000, 0);
      chk("bp_ready", d_ready, 1'b0);
      chk("bp_hold0", d_dout[15:8], 8'h11);
      cyc(1, 2'd1, 8'h22, 4'b0000, 0);
      chk("bp_hold1", d_dout[15:8], 8'h11);
      cyc(1, 2'd1, 8'h22, 4'b0010, 0);
      chk("ackwr_ready", d_ready, 1'b1);
      cyc(0, 0, 0, 0, 0);
      chk("ackwr_data", d_dout[15:8], 8'h22);
      chk("ackwr_vout", d_vout, 4'b0110);

      // ack empties channel 2, data retained; ack on empty ignored
      cyc(0, 0, 0, 4'b0100, 0);
      cyc(0, 0, 0, 4'b0100, 0);
      chk("ack_vout", d_vout, 4'b0010);
      chk("ack_keep", d_dout[23:16], 8'hA5);
      cyc(0, 0, 0, 0, 0);
      chk("ackempty_vout", d_vout, 4'b0010);

      // fill all, then flush with acks and a pending write
      cyc(1, 2'd0, 8'h30, 0, 0);
      cyc(1, 2'd2, 8'h32, 0, 0);
      cyc(1, 2'd3, 8'h33, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("fill_vout", d_vout, 4'b1111);
      chk("fill_dout", d_dout, 32'h3332_2230);
      cyc(1, 2'd0, 8'hFF, 4'b1111, 1);
      chk("flush_ready", d_ready, 1'b0);
      cyc(0, 0, 0, 0, 0);
      chk("flush_vout", d_vout, 4'b0000);
      chk("flush_dout", d_dout, 32'h3332_2230);

      // asynchronous reset between edges
      cyc(1, 2'd0, 8'h5A, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("pre_rst_vout", d_vout, 4'b0001);
      #1;
      rst_n   = 1'b0;
      d_valid = 1; d_sel = 0; d_data = 8'h7E;
      #1;
      chk("arst_vout", d_vout, 4'b0000);
      chk("arst_dout", d_dout, 32'h0);
      chk("arst_ready", d_ready, 1'b1);
      #1;
      rst_n = 1'b1;
      cyc(0, 0, 0, 0, 0);
      chk("post_rst_vout", d_vout, 4'b0001);
      chk("post_rst_data", d_dout[7:0], 8'h7E);

      // random traffic against the scoreboard
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      mfull = 4'b0000;
      for (int k = 0; k < 400; k++) begin
         cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             8'($urandom), 4'($urandom), 0);
         chk("rnd_vout", d_vout, mfull);
         exp_rdy = !mfull[d_sel] || d_ack[d_sel];
         chk("rnd_ready", d_ready, exp_rdy);
         for (int c = 0; c < 4; c++) begin
            if (d_ack[c] && mfull[c]) begin
               expw = sb[c].pop_front();
               chk("rnd_data", d_dout[c*8 +: 8], expw);
               mfull[c] = 1'b0;
            end
         end
         if (d_valid && exp_rdy) begin
            sb[d_sel].push_back(d_data);
            mfull[d_sel] = 1'b1;
         end
      end
      cyc(0, 0, 0, 4'b1111, 0);
      chk("drain_vout", d_vout, mfull);
      for (int c = 0; c < 4; c++) begin
         if (mfull[c]) begin
            expw = sb[c].pop_front();
            chk("drain_data", d_dout[c*8 +: 8], expw);
         end
      end
      cyc(0, 0, 0, 0, 0);
      chk("drain_empty", d_vout, 4'b0000);
      left = 0;
      for (int c = 0; c < 4; c++) left += sb[c].size();
      chk("sb_left", left, 0);

      // 3-channel instance: out-of-range drops and saturation
      npulse = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         t_valid = 1'b1;
         t_sel   = 2'd3;
         t_data  = 8'(k);
         #1;
         if (k > 0) npulse += int'(t_err);
         if (k == 0) chk("oor_ready", t_ready, 1'b1);
         if (k == 100) chk("oor_cnt100", t_drop, 8'd100);
      end
      @(negedge clk);
      t_valid = 1'b0;
      #1;
      npulse += int'(t_err);
      @(negedge clk);
      #1;
      chk("oor_err_end", t_err, 1'b0);
      chk("oor_pulses", npulse, 300);
      chk("oor_sat", t_drop, 8'd255);
      chk("oor_vout", t_vout, 3'b000);
      chk("oor_dout", t_dout, 24'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
